// File: rtl/numbers_arith_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : numbers_arith_scheduler
//  Description : Two-requester round-robin front end for a small arithmetic
//                datapath: sum/diff/prod in one cycle, quot/rem through an
//                8-iteration restoring divider, single tagged response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module numbers_arith_scheduler #(
  parameter logic [4:0] DZ_QUOT = 5'h1F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [4:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [4:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_err,
  output logic       busy
);

  localparam logic [2:0] c_OP_SUM  = 3'd0;
  localparam logic [2:0] c_OP_DIFF = 3'd1;
  localparam logic [2:0] c_OP_PROD = 3'd2;
  localparam logic [2:0] c_OP_QUOT = 3'd3;
  localparam logic [2:0] c_OP_REM  = 3'd4;
  localparam logic [2:0] c_LAST_ITER = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_last;       // id of the requester served most recently
  logic       r_id;
  logic [2:0] r_op;
  logic [4:0] r_b;
  logic [7:0] r_dvd;        // dividend shifts out MSB-first, quotient shifts in
  logic [5:0] r_rem;        // partial remainder
  logic [2:0] r_cnt;
  logic       r_rsp_valid;
  logic [4:0] r_rsp_data;
  logic       r_rsp_err;

  logic       w_grant0;
  logic       w_grant1;
  logic       w_accept;
  logic [7:0] w_sel_a;
  logic [4:0] w_sel_b;
  logic [2:0] w_sel_op;
  logic       w_is_div;
  logic [4:0] w_fast_data;
  logic       w_fast_err;
  logic [6:0] w_rem_shift;
  logic       w_sub_ok;
  logic [5:0] w_rem_next;
  logic [4:0] w_quo_final;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (r_last) w_grant0 = 1'b1;
      else        w_grant1 = 1'b1;
    end else if (req0_valid) begin
      w_grant0 = 1'b1;
    end else if (req1_valid) begin
      w_grant1 = 1'b1;
    end
  end

  assign req0_ready = (r_state == ST_IDLE) && w_grant0;
  assign req1_ready = (r_state == ST_IDLE) && w_grant1;
  assign w_accept   = req0_ready || req1_ready;

  assign w_sel_a  = w_grant1 ? req1_a  : req0_a;
  assign w_sel_b  = w_grant1 ? req1_b  : req0_b;
  assign w_sel_op = w_grant1 ? req1_op : req0_op;
  assign w_is_div = ((w_sel_op == c_OP_QUOT) || (w_sel_op == c_OP_REM)) && (w_sel_b != 5'd0);

  // Single-cycle results; only the low 5 bits of a matter modulo 32
  always_comb begin
    w_fast_data = 5'd0;
    w_fast_err  = 1'b0;
    case (w_sel_op)
      c_OP_SUM:  w_fast_data = w_sel_a[4:0] + w_sel_b;
      c_OP_DIFF: w_fast_data = w_sel_a[4:0] - w_sel_b;
      c_OP_PROD: w_fast_data = w_sel_a[4:0] * w_sel_b;
      c_OP_QUOT: begin
        w_fast_data = DZ_QUOT;
        w_fast_err  = 1'b1;
      end
      c_OP_REM: begin
        w_fast_data = w_sel_a[4:0];
        w_fast_err  = 1'b1;
      end
      default: begin
        w_fast_data = 5'd0;
        w_fast_err  = 1'b1;
      end
    endcase
  end

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  assign w_rem_shift = {r_rem, r_dvd[7]};
  assign w_sub_ok    = (w_rem_shift >= {2'b00, r_b});
  assign w_rem_next  = w_sub_ok ? 6'(w_rem_shift - {2'b00, r_b}) : w_rem_shift[5:0];
  assign w_quo_final = {r_dvd[3:0], w_sub_ok};

  // Control FSM plus operand, divider and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_op        <= 3'd0;
      r_b         <= 5'd0;
      r_dvd       <= 8'd0;
      r_rem       <= 6'd0;
      r_cnt       <= 3'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 5'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id  <= w_grant1;
            r_op  <= w_sel_op;
            r_b   <= w_sel_b;
            r_dvd <= w_sel_a;
            r_rem <= 6'd0;
            r_cnt <= 3'd0;
            if (w_is_div) begin
              r_state <= ST_DIV;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_fast_data;
              r_rsp_err   <= w_fast_err;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_DIV: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[6:0], w_sub_ok};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == c_LAST_ITER) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= (r_op == c_OP_QUOT) ? w_quo_final : w_rem_next[4:0];
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_last      <= r_id;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign rsp_id    = r_id;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_numbers_arith_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_numbers_arith_scheduler
//  Description : Self-checking bench for numbers_arith_scheduler against a
//                plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_numbers_arith_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req1_a = '0;
  logic [4:0] req0_b = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [4:0] rsp_data;
  logic       rsp_id;
  logic       rsp_err;
  logic       busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  numbers_arith_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules
  function automatic void model(input int a, input int b, input int op,
                                output int data, output int err, output int lat);
    err = 0;
    lat = 1;
    case (op)
      0: data = (a + b) % 32;
      1: data = (((a - b) % 32) + 32) % 32;
      2: data = (a * b) % 32;
      3: if (b == 0) begin data = 31; err = 1; end
         else begin data = (a / b) % 32; lat = 9; end
      4: if (b == 0) begin data = a % 32; err = 1; end
         else begin data = a % b; lat = 9; end
      default: begin data = 0; err = 1; end
    endcase
  endfunction

  task automatic drive(input int port, input bit v, input int a, input int b, input int op);
    if (port == 0) begin
      req0_valid = v; req0_a = a[7:0]; req0_b = b[4:0]; req0_op = op[2:0];
    end else begin
      req1_valid = v; req1_a = a[7:0]; req1_b = b[4:0]; req1_op = op[2:0];
    end
  endtask

  // Count edges from acceptance until rsp_valid is seen (bounded)
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One isolated transaction on one port; caller sits at posedge+1 in IDLE
  task automatic run_one(input int port, input int a, input int b, input int op);
    int ed, ee, el, lat;
    model(a, b, op, ed, ee, el);
    drive(port, 1'b1, a, b, op);
    #1;
    check("grant_ready", (port == 0) ? req0_ready : req1_ready, 1);
    @(posedge clk); #1;
    drive(port, 1'b0, a, b, op);
    wait_rsp(lat);
    check("latency", lat, el);
    check("rsp_data", rsp_data, ed);
    check("rsp_err", rsp_err, ee);
    check("rsp_id", rsp_id, port);
    check("busy_resp", busy, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_after_hs", rsp_valid, 0);
    check("busy_after_hs", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int pa[2], pb[2], po[2];
    int g, exp_last, ed, ee, el, lat, seen;

    // Reset values
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // Directed single-cycle ops, divisions, errors
    run_one(0, 200, 31, 0);
    run_one(0, 3, 5, 1);
    run_one(0, 13, 7, 2);
    run_one(1, 200, 7, 3);
    run_one(1, 200, 7, 4);
    run_one(1, 255, 1, 3);
    run_one(0, 8'h2A, 0, 3);
    run_one(0, 8'h2A, 0, 4);
    run_one(1, 8'h2A, 9, 6);

    // Randomized single-port transactions
    for (int k = 0; k < 30; k++) begin
      run_one($urandom_range(0, 1), $urandom_range(0, 255),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31),
              $urandom_range(0, 7));
    end

    // Arbitration: both valid continuously, responses alternate from id 0
    do_reset();
    exp_last = 1;
    for (int p = 0; p < 2; p++) begin
      pa[p] = $urandom_range(0, 255); pb[p] = $urandom_range(0, 31); po[p] = $urandom_range(0, 7);
      drive(p, 1'b1, pa[p], pb[p], po[p]);
    end
    for (int k = 0; k < 12; k++) begin
      #1;
      g = (exp_last == 1) ? 0 : 1;
      check("arb_ready0", req0_ready, (g == 0) ? 1 : 0);
      check("arb_ready1", req1_ready, (g == 1) ? 1 : 0);
      model(pa[g], pb[g], po[g], ed, ee, el);
      @(posedge clk); #1;
      pa[g] = $urandom_range(0, 255); pb[g] = $urandom_range(0, 31); po[g] = $urandom_range(0, 7);
      drive(g, 1'b1, pa[g], pb[g], po[g]);
      wait_rsp(lat);
      check("arb_busy_ready", {30'd0, req0_ready, req1_ready}, 0);
      check("arb_id", rsp_id, g);
      check("arb_data", rsp_data, ed);
      check("arb_err", rsp_err, ee);
      check("arb_lat", lat, el);
      @(posedge clk); #1;
      exp_last = g;
    end
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    @(posedge clk); #1;

    // Backpressure: response held for 5 cycles with a competing request
    rsp_ready = 1'b0;
    drive(0, 1'b1, 100, 9, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b1, 77, 3, 2);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 13);
      check("bp_ready", {30'd0, req0_ready, req1_ready}, 0);
      check("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 0, 0, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_busy", busy, 0);

    // Reset in the middle of a divide
    drive(1, 1'b1, 200, 7, 3);
    #1;
    check("md_ready1", req1_ready, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    check("md_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("md_valid_async", rsp_valid, 0);
    check("md_busy_async", busy, 0);
    check("md_data_async", rsp_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen++;
    end
    check("md_no_response", seen, 0);
    run_one(0, 17, 20, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
